feature_map_streamer: RTL

FEATURE_MAP_STREAMER -- requirements
Module: feature_map_streamer

---
 rtl/feature_map_streamer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/feature_map_streamer.sv
// feature_map_streamer
//   Stores a CORE_W x CORE_H feature map written one pixel at a time. On start,
//   streams it out in raster order as an IMAGE_WIDTH x IMAGE_HEIGHT frame with a
//   PAD-wide zero border.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   wr_en      store wr_data at the next fill address (IDLE, not yet full)
//   wr_data    core pixel value
//   start      begin streaming one frame (accepted only when load_full=1)
//   stall      freezes the raster scan while high
//   out        padded raster pixel, 0 whenever valid_out=0
//   valid_out  qualifies out
//   load_full  every core pixel has been stored
//   busy       high while scanning (STREAM)
//   done       one-cycle pulse alongside the final pixel of the frame
module feature_map_streamer #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 14,
  parameter int IMAGE_HEIGHT = 14,
  parameter int PAD          = 1,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  valid_out,
  output logic                  load_full,
  output logic                  busy,
  output logic                  done
);

  localparam int CORE_W = IMAGE_WIDTH - 2 * PAD;
  localparam int CORE_H = IMAGE_HEIGHT - 2 * PAD;
  localparam int CORE_N = CORE_W * CORE_H;
  localparam int ADDR_W = (CORE_N > 1) ? $clog2(CORE_N) : 1;

  localparam logic [CNT_WIDTH-1:0] LAST_COL  = CNT_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_ROW  = CNT_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_FILL = CNT_WIDTH'(CORE_N - 1);
  localparam logic [CNT_WIDTH-1:0] PAD_LO    = CNT_WIDTH'(PAD);
  localparam logic [CNT_WIDTH-1:0] COL_HI    = CNT_WIDTH'(IMAGE_WIDTH - PAD);
  localparam logic [CNT_WIDTH-1:0] ROW_HI    = CNT_WIDTH'(IMAGE_HEIGHT - PAD);
  localparam logic [CNT_WIDTH-1:0] CORE_W_C  = CNT_WIDTH'(CORE_W);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  logic [DATA_WIDTH-1:0] core_mem [CORE_N];
  logic [DATA_WIDTH-1:0] rd_data_q;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  fill_q, fill_d;
  logic                  load_full_q, load_full_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_pad_q, s1_pad_d;
  logic                  s1_last_q, s1_last_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic                  interior;
  logic                  mem_we;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    load_full_d = load_full_q;
    row_d       = row_q;
    col_d       = col_q;
    s1_valid_d  = 1'b0;
    s1_pad_d    = 1'b0;
    s1_last_d   = 1'b0;
    mem_we      = 1'b0;
    wr_addr     = ADDR_W'(fill_q);
    rd_addr     = '0;

    interior = (row_q >= PAD_LO) && (row_q < ROW_HI) &&
               (col_q >= PAD_LO) && (col_q < COL_HI);
    // Border positions read address 0 so the memory is never indexed out of range.
    if (interior) begin
      rd_addr = ADDR_W'((row_q - PAD_LO) * CORE_W_C + (col_q - PAD_LO));
    end

    // Stage 2 consumes what stage 1 captured on the previous edge.
    valid_d = s1_valid_q;
    out_d   = (s1_valid_q && !s1_pad_q) ? rd_data_q : '0;
    done_d  = s1_valid_q && s1_last_q;

    unique case (state_q)
      IDLE: begin
        if (wr_en && !load_full_q) begin
          mem_we = 1'b1;
          fill_d = fill_q + 1'b1;
          if (fill_q == LAST_FILL) begin
            load_full_d = 1'b1;
          end
        end
        if (start && load_full_q) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (!stall) begin
          s1_valid_d = 1'b1;
          s1_pad_d   = !interior;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d     = '0;
              s1_last_d = 1'b1;
              state_d   = DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        // The stored frame is consumed; a fresh load is required before the next start.
        state_d     = IDLE;
        fill_d      = '0;
        load_full_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      load_full_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_pad_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      load_full_q <= load_full_d;
      row_q       <= row_d;
      col_q       <= col_d;
      s1_valid_q  <= s1_valid_d;
      s1_pad_q    <= s1_pad_d;
      s1_last_q   <= s1_last_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  // Core storage is deliberately not reset; contents are don't-care until reloaded.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      core_mem[wr_addr] <= wr_data;
    end
    rd_data_q <= core_mem[rd_addr];
  end

  assign out       = out_q;
  assign valid_out = valid_q;
  assign load_full = load_full_q;
  assign busy      = (state_q == STREAM);
  assign done      = done_q;

endmodule
